// File: rtl/xgemac_rtl_pkg.sv
package xgemac_rtl_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : int'($clog2(n));
  endfunction

endpackage

// File: rtl/xgemac_rr_arbiter.sv
module xgemac_rr_arbiter
  import xgemac_rtl_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = clog2_min1(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   gnt_idx,
  output logic              any
);

  logic [CH_W-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int unsigned off = 1; off <= NUM_CH; off++) begin
      idx = CH_W'((32'(last) + off) % NUM_CH);
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt_idx  = idx;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xgemac_tx_pkt_arbiter.sv
module xgemac_tx_pkt_arbiter
  import xgemac_rtl_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned MOD_W  = clog2_min1(DATA_W / 8),
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned CH_W   = clog2_min1(NUM_CH)
) (
  input  logic                      clk_156m25,
  input  logic                      reset_156m25_n,
  input  logic [NUM_CH*DATA_W-1:0]  ch_data,
  input  logic [NUM_CH-1:0]         ch_val,
  input  logic [NUM_CH-1:0]         ch_sop,
  input  logic [NUM_CH-1:0]         ch_eop,
  input  logic [NUM_CH*MOD_W-1:0]   ch_mod,
  output logic [NUM_CH-1:0]         ch_rdy,
  output logic [DATA_W-1:0]         pkt_tx_data,
  output logic                      pkt_tx_val,
  output logic                      pkt_tx_sop,
  output logic                      pkt_tx_eop,
  output logic [MOD_W-1:0]          pkt_tx_mod,
  input  logic                      pkt_tx_full,
  output logic                      busy,
  output logic [CH_W-1:0]           grant_ch,
  output logic                      proto_err,
  output logic [CNT_W-1:0]          err_cnt,
  output logic [NUM_CH*CNT_W-1:0]   pkt_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
    logic [MOD_W-1:0]  mod;
  } pkt_word_t;

  arb_state_e        state, next_state;
  logic [CH_W-1:0]   last_grant;
  logic [DATA_W-1:0] data_arr [NUM_CH];
  logic [MOD_W-1:0]  mod_arr  [NUM_CH];
  logic [CNT_W-1:0]  cnt_arr  [NUM_CH];
  logic [NUM_CH-1:0] sop_req, stray_req, sop_gnt, stray_gnt;
  logic [CH_W-1:0]   sop_idx, stray_idx, sel_idx;
  logic              sop_any, stray_any;
  logic              fwd, err, pkt_done;
  pkt_word_t         fwd_word;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign data_arr[i]                = ch_data[i*DATA_W +: DATA_W];
    assign mod_arr[i]                 = ch_mod[i*MOD_W +: MOD_W];
    assign pkt_cnt[i*CNT_W +: CNT_W]  = cnt_arr[i];
  end

  assign sop_req   = ch_val & ch_sop;
  assign stray_req = ch_val & ~ch_sop;
  assign busy      = (state == ARB_LOCKED);

  xgemac_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_rr (
    .req     (sop_req),
    .last    (last_grant),
    .gnt     (sop_gnt),
    .gnt_idx (sop_idx),
    .any     (sop_any)
  );

  always_comb begin
    stray_gnt = '0;
    stray_idx = '0;
    stray_any = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!stray_any && stray_req[i]) begin
        stray_any    = 1'b1;
        stray_idx    = CH_W'(i);
        stray_gnt[i] = 1'b1;
      end
    end
  end

  // ch_rdy is gated by reset as well, so nothing is accepted while reset is held
  always_comb begin
    next_state = state;
    ch_rdy     = '0;
    sel_idx    = grant_ch;
    fwd        = 1'b0;
    err        = 1'b0;
    pkt_done   = 1'b0;
    if (reset_156m25_n && !pkt_tx_full) begin
      case (state)
        ARB_IDLE: begin
          if (sop_any) begin
            ch_rdy  = sop_gnt;
            sel_idx = sop_idx;
            fwd     = 1'b1;
            if (ch_eop[sop_idx]) pkt_done = 1'b1;
            else                 next_state = ARB_LOCKED;
          end else if (stray_any) begin
            ch_rdy = stray_gnt;
            err    = 1'b1;
          end
        end
        ARB_LOCKED: begin
          ch_rdy[grant_ch] = 1'b1;
          if (ch_val[grant_ch]) begin
            fwd = 1'b1;
            if (ch_sop[grant_ch]) err = 1'b1;
            if (ch_eop[grant_ch]) begin
              pkt_done   = 1'b1;
              next_state = ARB_IDLE;
            end
          end
        end
        default: next_state = ARB_IDLE;
      endcase
    end
    fwd_word.data = data_arr[sel_idx];
    fwd_word.sop  = (state == ARB_IDLE);
    fwd_word.eop  = ch_eop[sel_idx];
    fwd_word.mod  = ch_eop[sel_idx] ? mod_arr[sel_idx] : '0;
  end

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      state       <= ARB_IDLE;
      last_grant  <= CH_W'(NUM_CH - 1);
      grant_ch    <= '0;
      pkt_tx_data <= '0;
      pkt_tx_val  <= 1'b0;
      pkt_tx_sop  <= 1'b0;
      pkt_tx_eop  <= 1'b0;
      pkt_tx_mod  <= '0;
      proto_err   <= 1'b0;
      err_cnt     <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) cnt_arr[i] <= '0;
    end else begin
      state       <= next_state;
      pkt_tx_val  <= fwd;
      pkt_tx_data <= fwd ? fwd_word.data : '0;
      pkt_tx_sop  <= fwd & fwd_word.sop;
      pkt_tx_eop  <= fwd & fwd_word.eop;
      pkt_tx_mod  <= fwd ? fwd_word.mod : '0;
      proto_err   <= err;
      if (err && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
      if (fwd && (state == ARB_IDLE)) grant_ch <= sel_idx;
      if (pkt_done) begin
        last_grant       <= sel_idx;
        cnt_arr[sel_idx] <= cnt_arr[sel_idx] + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_xgemac_tx_pkt_arbiter.sv
module tb_xgemac_tx_pkt_arbiter;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 64;
  localparam int MOD_W  = 3;
  localparam int CNT_W  = 16;
  localparam int CH_W   = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_val, ch_sop, ch_eop, ch_rdy;
  logic [NUM_CH*MOD_W-1:0]  ch_mod;
  logic [DATA_W-1:0]        pkt_tx_data;
  logic                     pkt_tx_val, pkt_tx_sop, pkt_tx_eop;
  logic [MOD_W-1:0]         pkt_tx_mod;
  logic                     pkt_tx_full;
  logic                     busy;
  logic [CH_W-1:0]          grant_ch;
  logic                     proto_err;
  logic [CNT_W-1:0]         err_cnt;
  logic [NUM_CH*CNT_W-1:0]  pkt_cnt;

  int n_pass  = 0;
  int n_total = 0;

  always #3 clk = ~clk;

  xgemac_tx_pkt_arbiter #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .MOD_W  (MOD_W),
    .CNT_W  (CNT_W),
    .CH_W   (CH_W)
  ) dut (
    .clk_156m25     (clk),
    .reset_156m25_n (rst_n),
    .ch_data        (ch_data),
    .ch_val         (ch_val),
    .ch_sop         (ch_sop),
    .ch_eop         (ch_eop),
    .ch_mod         (ch_mod),
    .ch_rdy         (ch_rdy),
    .pkt_tx_data    (pkt_tx_data),
    .pkt_tx_val     (pkt_tx_val),
    .pkt_tx_sop     (pkt_tx_sop),
    .pkt_tx_eop     (pkt_tx_eop),
    .pkt_tx_mod     (pkt_tx_mod),
    .pkt_tx_full    (pkt_tx_full),
    .busy           (busy),
    .grant_ch       (grant_ch),
    .proto_err      (proto_err),
    .err_cnt        (err_cnt),
    .pkt_cnt        (pkt_cnt)
  );

  task automatic drive(input int ch, input logic v, input logic s, input logic e,
                       input logic [MOD_W-1:0] m, input logic [DATA_W-1:0] d);
    ch_val[ch] = v;
    ch_sop[ch] = s;
    ch_eop[ch] = e;
    ch_mod[ch*MOD_W +: MOD_W]    = m;
    ch_data[ch*DATA_W +: DATA_W] = d;
  endtask

  task automatic idle_all();
    ch_val  = '0;
    ch_sop  = '0;
    ch_eop  = '0;
    ch_mod  = '0;
    ch_data = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n       = 1'b0;
    pkt_tx_full = 1'b0;
    idle_all();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_total++; if (pkt_tx_val !== 1'b0) $display("FAIL reset_val got %b want 0", pkt_tx_val); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_total++; if (grant_ch !== 2'd0) $display("FAIL reset_grant got %0d want 0", grant_ch); else n_pass++;
    n_total++; if (err_cnt !== 16'd0) $display("FAIL reset_err_cnt got %0d want 0", err_cnt); else n_pass++;
    n_total++; if (pkt_cnt !== '0) $display("FAIL reset_pkt_cnt got %h want 0", pkt_cnt); else n_pass++;
    n_total++; if (ch_rdy !== 4'b0000) $display("FAIL reset_rdy got %b want 0000", ch_rdy); else n_pass++;
  endtask

  task automatic test_single_packet();
    int busy_cyc = 0;
    logic [DATA_W-1:0] exp_d;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      exp_d = 64'hA000 + 64'(i);
      drive(0, 1'b1, i == 0, i == 3, (i == 3) ? 3'd5 : 3'd7, exp_d);
      #1;
      n_total++; if (ch_rdy !== 4'b0001) $display("FAIL single_rdy w%0d got %b want 0001", i, ch_rdy); else n_pass++;
      step();
      n_total++;
      if (pkt_tx_val !== 1'b1 || pkt_tx_data !== exp_d || pkt_tx_sop !== (i == 0) ||
          pkt_tx_eop !== (i == 3) || pkt_tx_mod !== ((i == 3) ? 3'd5 : 3'd0))
        $display("FAIL single_word w%0d got val=%b sop=%b eop=%b mod=%0d data=%h want val=1 sop=%b eop=%b mod=%0d data=%h",
                 i, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data,
                 i == 0, i == 3, (i == 3) ? 5 : 0, exp_d);
      else n_pass++;
      if (busy) busy_cyc++;
    end
    idle_all();
    step();
    n_total++; if (pkt_tx_val !== 1'b0) $display("FAIL single_idle_val got %b want 0", pkt_tx_val); else n_pass++;
    n_total++; if (pkt_cnt[0 +: CNT_W] !== 16'd1) $display("FAIL single_pkt_cnt got %0d want 1", pkt_cnt[0 +: CNT_W]); else n_pass++;
    n_total++; if (busy_cyc != 3) $display("FAIL single_busy_cycles got %0d want 3", busy_cyc); else n_pass++;
  endtask

  task automatic test_round_robin();
    int w [NUM_CH];
    logic [NUM_CH-1:0] rdy;
    int exp_ch, exp_w;
    apply_reset();
    for (int ch = 0; ch < NUM_CH; ch++) w[ch] = 0;
    for (int c = 0; c < 10; c++) begin
      for (int ch = 0; ch < NUM_CH; ch++)
        drive(ch, 1'b1, w[ch] == 0, w[ch] == 1, 3'd0, 64'(ch * 256 + w[ch]));
      #1;
      rdy = ch_rdy;
      step();
      exp_ch = (c / 2) % NUM_CH;
      exp_w  = c % 2;
      n_total++;
      if (pkt_tx_val !== 1'b1 || pkt_tx_data !== 64'(exp_ch * 256 + exp_w) || pkt_tx_sop !== (exp_w == 0))
        $display("FAIL rr_word c%0d got val=%b sop=%b data=%h want val=1 sop=%b data=%h",
                 c, pkt_tx_val, pkt_tx_sop, pkt_tx_data, exp_w == 0, 64'(exp_ch * 256 + exp_w));
      else n_pass++;
      for (int ch = 0; ch < NUM_CH; ch++)
        if (rdy[ch]) w[ch] = 1 - w[ch];
    end
    idle_all();
    step();
    n_total++; if (pkt_cnt[0 +: CNT_W] !== 16'd2) $display("FAIL rr_cnt0 got %0d want 2", pkt_cnt[0 +: CNT_W]); else n_pass++;
    n_total++; if (pkt_cnt[3*CNT_W +: CNT_W] !== 16'd1) $display("FAIL rr_cnt3 got %0d want 1", pkt_cnt[3*CNT_W +: CNT_W]); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] exp_d;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      exp_d = 64'hC200 + 64'(i);
      drive(2, 1'b1, i == 0, i == 5, (i == 5) ? 3'd3 : 3'd0, exp_d);
      if (i == 2) begin
        pkt_tx_full = 1'b1;
        #1;
        n_total++;
        if (pkt_tx_val !== 1'b1 || pkt_tx_data !== 64'hC201)
          $display("FAIL bp_inflight got val=%b data=%h want val=1 data=c201", pkt_tx_val, pkt_tx_data);
        else n_pass++;
        repeat (5) begin
          n_total++; if (ch_rdy !== 4'b0000) $display("FAIL bp_rdy_full got %b want 0000", ch_rdy); else n_pass++;
          step();
          n_total++; if (pkt_tx_val !== 1'b0 || proto_err !== 1'b0)
            $display("FAIL bp_stall got val=%b perr=%b want val=0 perr=0", pkt_tx_val, proto_err); else n_pass++;
        end
        pkt_tx_full = 1'b0;
      end
      #1;
      n_total++; if (ch_rdy !== 4'b0100) $display("FAIL bp_rdy w%0d got %b want 0100", i, ch_rdy); else n_pass++;
      step();
      n_total++;
      if (pkt_tx_val !== 1'b1 || pkt_tx_data !== exp_d || pkt_tx_sop !== (i == 0) ||
          pkt_tx_eop !== (i == 5) || pkt_tx_mod !== ((i == 5) ? 3'd3 : 3'd0) || proto_err !== 1'b0)
        $display("FAIL bp_word w%0d got val=%b sop=%b eop=%b mod=%0d data=%h perr=%b want data=%h",
                 i, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data, proto_err, exp_d);
      else n_pass++;
    end
    idle_all();
    step();
    n_total++; if (pkt_cnt[2*CNT_W +: CNT_W] !== 16'd1) $display("FAIL bp_cnt2 got %0d want 1", pkt_cnt[2*CNT_W +: CNT_W]); else n_pass++;
    n_total++; if (err_cnt !== 16'd0) $display("FAIL bp_err_cnt got %0d want 0", err_cnt); else n_pass++;
  endtask

  task automatic test_stray();
    apply_reset();
    drive(1, 1'b1, 1'b0, 1'b0, 3'd0, 64'hDEAD);
    #1;
    n_total++; if (ch_rdy !== 4'b0010) $display("FAIL stray_rdy got %b want 0010", ch_rdy); else n_pass++;
    step();
    idle_all();
    n_total++; if (proto_err !== 1'b1 || pkt_tx_val !== 1'b0)
      $display("FAIL stray_drop got perr=%b val=%b want perr=1 val=0", proto_err, pkt_tx_val); else n_pass++;
    n_total++; if (err_cnt !== 16'd1) $display("FAIL stray_err_cnt got %0d want 1", err_cnt); else n_pass++;
    step();
    n_total++; if (proto_err !== 1'b0) $display("FAIL stray_pulse got %b want 0", proto_err); else n_pass++;
    drive(1, 1'b1, 1'b0, 1'b0, 3'd0, 64'hDEAD);
    drive(2, 1'b1, 1'b1, 1'b1, 3'd4, 64'hBEEF);
    #1;
    n_total++; if (ch_rdy !== 4'b0100) $display("FAIL stray_vs_sop_rdy got %b want 0100", ch_rdy); else n_pass++;
    step();
    idle_all();
    n_total++;
    if (pkt_tx_val !== 1'b1 || pkt_tx_sop !== 1'b1 || pkt_tx_eop !== 1'b1 || pkt_tx_mod !== 3'd4 ||
        pkt_tx_data !== 64'hBEEF || proto_err !== 1'b0 || busy !== 1'b0)
      $display("FAIL single_word_pkt got val=%b sop=%b eop=%b mod=%0d data=%h perr=%b busy=%b want 1 1 1 4 beef 0 0",
               pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data, proto_err, busy);
    else n_pass++;
    step();
    n_total++; if (pkt_cnt[2*CNT_W +: CNT_W] !== 16'd1 || err_cnt !== 16'd1)
      $display("FAIL stray_counts got cnt2=%0d err=%0d want 1 1", pkt_cnt[2*CNT_W +: CNT_W], err_cnt); else n_pass++;
  endtask

  task automatic test_sop_in_lock();
    apply_reset();
    drive(3, 1'b1, 1'b1, 1'b0, 3'd0, 64'h3000);
    step();
    drive(3, 1'b1, 1'b1, 1'b0, 3'd0, 64'h3001);
    step();
    n_total++;
    if (pkt_tx_val !== 1'b1 || pkt_tx_sop !== 1'b0 || pkt_tx_data !== 64'h3001 || proto_err !== 1'b1 ||
        err_cnt !== 16'd1 || busy !== 1'b1)
      $display("FAIL dup_sop got val=%b sop=%b data=%h perr=%b err=%0d busy=%b want 1 0 3001 1 1 1",
               pkt_tx_val, pkt_tx_sop, pkt_tx_data, proto_err, err_cnt, busy);
    else n_pass++;
    drive(3, 1'b1, 1'b0, 1'b1, 3'd2, 64'h3002);
    step();
    idle_all();
    n_total++; if (pkt_tx_eop !== 1'b1 || pkt_tx_mod !== 3'd2 || proto_err !== 1'b0)
      $display("FAIL dup_sop_eop got eop=%b mod=%0d perr=%b want 1 2 0", pkt_tx_eop, pkt_tx_mod, proto_err); else n_pass++;
    step();
    n_total++; if (pkt_cnt[3*CNT_W +: CNT_W] !== 16'd1) $display("FAIL dup_sop_cnt3 got %0d want 1", pkt_cnt[3*CNT_W +: CNT_W]); else n_pass++;
    drive(1, 1'b1, 1'b0, 1'b0, 3'd0, 64'hDEAD);
    repeat (65540) @(posedge clk);
    #1;
    n_total++; if (err_cnt !== 16'hFFFF || proto_err !== 1'b1)
      $display("FAIL err_sat got err=%h perr=%b want ffff 1", err_cnt, proto_err); else n_pass++;
    idle_all();
    step();
    n_total++; if (err_cnt !== 16'hFFFF || proto_err !== 1'b0)
      $display("FAIL err_sat_hold got err=%h perr=%b want ffff 0", err_cnt, proto_err); else n_pass++;
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    drive(3, 1'b1, 1'b1, 1'b0, 3'd0, 64'h3100);
    step();
    drive(3, 1'b1, 1'b0, 1'b0, 3'd0, 64'h3101);
    step();
    n_total++; if (busy !== 1'b1 || pkt_tx_val !== 1'b1)
      $display("FAIL rst_mid_pre got busy=%b val=%b want 1 1", busy, pkt_tx_val); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (pkt_tx_val !== 1'b0 || pkt_tx_eop !== 1'b0 || pkt_tx_data !== '0 || busy !== 1'b0 ||
        grant_ch !== 2'd0 || ch_rdy !== 4'b0000)
      $display("FAIL rst_mid_async got val=%b eop=%b data=%h busy=%b grant=%0d rdy=%b want all 0",
               pkt_tx_val, pkt_tx_eop, pkt_tx_data, busy, grant_ch, ch_rdy);
    else n_pass++;
    drive(3, 1'b1, 1'b1, 1'b1, 3'd0, 64'h003F);
    drive(0, 1'b1, 1'b1, 1'b1, 3'd0, 64'h000F);
    step();
    rst_n = 1'b1;
    #1;
    n_total++; if (ch_rdy !== 4'b0001) $display("FAIL rst_mid_prio got %b want 0001", ch_rdy); else n_pass++;
    step();
    idle_all();
    n_total++; if (pkt_tx_val !== 1'b1 || pkt_tx_data !== 64'h000F || pkt_tx_sop !== 1'b1)
      $display("FAIL rst_mid_first got val=%b sop=%b data=%h want 1 1 000f", pkt_tx_val, pkt_tx_sop, pkt_tx_data); else n_pass++;
    n_total++; if (pkt_cnt[3*CNT_W +: CNT_W] !== 16'd0)
      $display("FAIL rst_mid_cnt3 got %0d want 0", pkt_cnt[3*CNT_W +: CNT_W]); else n_pass++;
  endtask

  initial begin
    rst_n       = 1'b0;
    pkt_tx_full = 1'b0;
    idle_all();
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_stray();
    test_sop_in_lock();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
